// File: rtl/cpu_bus_pkg.sv
// Shared encodings for the CPU-side Wishbone initiator: FSM states, byte-lane selects and
// the default bus timeout.
package cpu_bus_pkg;

  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_BUS  = 1'b1;

  localparam logic [1:0] SEL_WORD = 2'b11;
  localparam logic [1:0] SEL_EVEN = 2'b01;
  localparam logic [1:0] SEL_ODD  = 2'b10;

  localparam int unsigned TIMEOUT_DEFAULT = 64;

  function automatic logic [1:0] lane_sel(input logic i_byte, input logic i_a0);
    if (!i_byte) return SEL_WORD;
    return i_a0 ? SEL_ODD : SEL_EVEN;
  endfunction

endpackage

// File: rtl/wb_timeout_cnt.sv
// Counts bus cycles spent waiting for an acknowledge; o_expire flags the last allowed cycle.
module wb_timeout_cnt
  import cpu_bus_pkg::*;
#(
  parameter int unsigned TIMEOUT = TIMEOUT_DEFAULT
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_clr,
  input  logic i_en,
  output logic o_expire
);

  logic [7:0] r_cnt;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_cnt <= '0;
    end else if (i_clr) begin
      r_cnt <= '0;
    end else if (i_en) begin
      r_cnt <= r_cnt + 8'd1;
    end
  end

  assign o_expire = i_en && (r_cnt == 8'(TIMEOUT - 1));

endmodule

// File: rtl/cpu_wb_master.sv
// Single-transfer Wishbone initiator for the PDP2011 CPU I/O port: lane steering,
// odd-address rejection and no-ack timeout.
module cpu_wb_master
  import cpu_bus_pkg::*;
#(
  parameter int unsigned AW      = 22,
  parameter int unsigned TIMEOUT = TIMEOUT_DEFAULT
) (
  input  logic          wb_clk_i,
  input  logic          wb_rst_i,
  input  logic          cpu_req,
  input  logic          cpu_we,
  input  logic          cpu_byte,
  input  logic [AW-1:0] cpu_adr,
  input  logic [15:0]   cpu_wdat,
  output logic [15:0]   cpu_rdat,
  output logic          cpu_busy,
  output logic          cpu_done,
  output logic          cpu_odd_err,
  output logic          cpu_timeout,
  output logic [AW-1:0] wb_adr_o,
  output logic [15:0]   wb_dat_o,
  input  logic [15:0]   wb_dat_i,
  output logic          wb_cyc_o,
  output logic          wb_stb_o,
  output logic          wb_we_o,
  output logic [1:0]    wb_sel_o,
  input  logic          wb_ack_i
);

  logic [0:0]    r_state;
  logic [AW-1:0] r_adr;
  logic [15:0]   r_wdat;
  logic [15:0]   r_rdat;
  logic          r_we;
  logic [1:0]    r_sel;
  logic          r_done;
  logic          r_odd;
  logic          r_to;

  logic          w_idle;
  logic          w_odd_req;
  logic          w_accept;
  logic          w_ack;
  logic          w_expire;
  logic [15:0]   w_rd_lane;

  assign w_idle    = (r_state == ST_IDLE);
  assign w_odd_req = w_idle && cpu_req && !cpu_byte && cpu_adr[0];
  assign w_accept  = w_idle && cpu_req && !w_odd_req;
  assign w_ack     = !w_idle && wb_ack_i;

  // Ack takes priority over expiry: the counter is only enabled on no-ack cycles.
  wb_timeout_cnt #(
    .TIMEOUT(TIMEOUT)
  ) u_timeout_cnt (
    .i_clk   (wb_clk_i),
    .i_rst   (wb_rst_i),
    .i_clr   (w_accept || w_ack || w_expire),
    .i_en    (!w_idle && !wb_ack_i),
    .o_expire(w_expire)
  );

  always_comb begin
    w_rd_lane = wb_dat_i;
    if (r_sel == SEL_ODD) begin
      w_rd_lane = {8'h00, wb_dat_i[15:8]};
    end else if (r_sel == SEL_EVEN) begin
      w_rd_lane = {8'h00, wb_dat_i[7:0]};
    end
  end

  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      r_state <= ST_IDLE;
      r_adr   <= '0;
      r_wdat  <= '0;
      r_rdat  <= '0;
      r_we    <= 1'b0;
      r_sel   <= '0;
      r_done  <= 1'b0;
      r_odd   <= 1'b0;
      r_to    <= 1'b0;
    end else begin
      r_done <= 1'b0;
      r_odd  <= 1'b0;
      r_to   <= 1'b0;
      if (w_idle) begin
        r_odd <= w_odd_req;
        if (w_accept) begin
          r_state <= ST_BUS;
          r_adr   <= {cpu_adr[AW-1:1], 1'b0};
          r_we    <= cpu_we;
          r_sel   <= lane_sel(cpu_byte, cpu_adr[0]);
          r_wdat  <= cpu_byte ? {2{cpu_wdat[7:0]}} : cpu_wdat;
        end
      end else if (w_ack) begin
        r_state <= ST_IDLE;
        r_we    <= 1'b0;
        r_sel   <= '0;
        r_done  <= 1'b1;
        if (!r_we) begin
          r_rdat <= w_rd_lane;
        end
      end else if (w_expire) begin
        r_state <= ST_IDLE;
        r_we    <= 1'b0;
        r_sel   <= '0;
        r_to    <= 1'b1;
      end
    end
  end

  assign cpu_rdat    = r_rdat;
  assign cpu_busy    = !w_idle;
  assign cpu_done    = r_done;
  assign cpu_odd_err = r_odd;
  assign cpu_timeout = r_to;
  assign wb_adr_o    = r_adr;
  assign wb_dat_o    = r_wdat;
  assign wb_cyc_o    = !w_idle;
  assign wb_stb_o    = !w_idle;
  assign wb_we_o     = r_we;
  assign wb_sel_o    = r_sel;

endmodule

// File: tb/tb_cpu_wb_master.sv
// Self-checking bench for cpu_wb_master with a zero-wait registered-ack responder.
`timescale 1ns/1ps
module tb_cpu_wb_master;

  localparam int unsigned AW = 22;
  localparam int unsigned TO = 64;

  logic          clk = 1'b0;
  logic          rst;
  logic          cpu_req, cpu_we, cpu_byte;
  logic [AW-1:0] cpu_adr;
  logic [15:0]   cpu_wdat, cpu_rdat;
  logic          cpu_busy, cpu_done, cpu_odd_err, cpu_timeout;
  logic [AW-1:0] wb_adr_o;
  logic [15:0]   wb_dat_o, wb_dat_i;
  logic          wb_cyc_o, wb_stb_o, wb_we_o, wb_ack_i;
  logic [1:0]    wb_sel_o;

  logic          resp_en, resp_ack, stray_ack;
  logic [15:0]   mem;

  cpu_wb_master #(
    .AW     (AW),
    .TIMEOUT(TO)
  ) dut (
    .wb_clk_i   (clk),
    .wb_rst_i   (rst),
    .cpu_req    (cpu_req),
    .cpu_we     (cpu_we),
    .cpu_byte   (cpu_byte),
    .cpu_adr    (cpu_adr),
    .cpu_wdat   (cpu_wdat),
    .cpu_rdat   (cpu_rdat),
    .cpu_busy   (cpu_busy),
    .cpu_done   (cpu_done),
    .cpu_odd_err(cpu_odd_err),
    .cpu_timeout(cpu_timeout),
    .wb_adr_o   (wb_adr_o),
    .wb_dat_o   (wb_dat_o),
    .wb_dat_i   (wb_dat_i),
    .wb_cyc_o   (wb_cyc_o),
    .wb_stb_o   (wb_stb_o),
    .wb_we_o    (wb_we_o),
    .wb_sel_o   (wb_sel_o),
    .wb_ack_i   (wb_ack_i)
  );

  always #5 clk = ~clk;

  assign wb_ack_i = resp_ack | stray_ack;
  assign wb_dat_i = mem;

  always @(posedge clk or posedge rst) begin
    if (rst) resp_ack <= 1'b0;
    else     resp_ack <= resp_en & wb_cyc_o & wb_stb_o & ~resp_ack;
  end

  int n_tests = 0;
  int n_fail  = 0;

  // Observations of one transaction, sampled on falling edges.
  int            o_cyc, o_done, o_done_idx, o_to, o_to_idx, o_odd, o_ack, o_busy_bad, o_drift;
  logic          o_first;
  logic [AW-1:0] o_adr;
  logic [15:0]   o_dat;
  logic [1:0]    o_sel;
  logic          o_we;

  // Expected cpu_rdat: the value of the last completed read.
  logic [15:0]   m_rdat;

  task automatic run_txn(input logic we, input logic byt, input logic [AW-1:0] adr,
                         input logic [15:0] wdat, input logic poke, input int ncyc);
    @(negedge clk);
    cpu_req = 1'b1; cpu_we = we; cpu_byte = byt; cpu_adr = adr; cpu_wdat = wdat;
    o_cyc = 0; o_done = 0; o_done_idx = -1; o_to = 0; o_to_idx = -1; o_odd = 0;
    o_ack = 0; o_busy_bad = 0; o_drift = 0; o_first = 1'b1;
    o_adr = '0; o_dat = '0; o_sel = '0; o_we = 1'b0;
    for (int i = 0; i < ncyc; i++) begin
      @(negedge clk);
      if (wb_cyc_o) begin
        o_cyc++;
        if (o_first) begin
          o_adr = wb_adr_o; o_dat = wb_dat_o; o_sel = wb_sel_o; o_we = wb_we_o;
          o_first = 1'b0;
        end else if ({o_adr, o_dat, o_sel, o_we} !== {wb_adr_o, wb_dat_o, wb_sel_o, wb_we_o}) begin
          o_drift++;
        end
      end
      if (cpu_busy !== wb_cyc_o || wb_stb_o !== wb_cyc_o) o_busy_bad++;
      if (cpu_done)    begin o_done++; o_done_idx = i; end
      if (cpu_timeout) begin o_to++;   o_to_idx = i;   end
      if (cpu_odd_err) o_odd++;
      if (wb_ack_i)    o_ack++;
      if (i == 0) begin
        cpu_req = 1'b0; cpu_we = ~we; cpu_byte = ~byt;
        cpu_adr = AW'($urandom); cpu_wdat = 16'($urandom);
      end
      if (i == 1 && poke) cpu_req = 1'b1;
      if (i == 2) cpu_req = 1'b0;
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    #1;
    n_tests++;
    if ({cpu_busy, cpu_done, cpu_odd_err, cpu_timeout, wb_cyc_o, wb_stb_o, wb_we_o, wb_sel_o}
        !== 10'b0) begin
      n_fail++;
      $display("FAIL reset_ctrl got busy%b done%b odd%b to%b cyc%b stb%b we%b sel%b want 0",
               cpu_busy, cpu_done, cpu_odd_err, cpu_timeout, wb_cyc_o, wb_stb_o, wb_we_o,
               wb_sel_o);
    end
    n_tests++;
    if ({cpu_rdat, wb_adr_o, wb_dat_o} !== '0) begin
      n_fail++;
      $display("FAIL reset_data got rdat %h adr %h dat %h want 0", cpu_rdat, wb_adr_o, wb_dat_o);
    end
    repeat (2) @(negedge clk);
    rst = 1'b0;
    m_rdat = 16'h0000;
  endtask

  task automatic test_word_read();
    resp_en = 1'b1; mem = 16'o000340;
    run_txn(1'b0, 1'b0, 22'o17777776, 16'h0, 1'b1, 8);
    m_rdat = 16'o000340;
    n_tests++; if (o_sel !== 2'b11) begin n_fail++; $display("FAIL wr_sel got %b want 11", o_sel); end
    n_tests++; if (o_cyc !== 2) begin n_fail++; $display("FAIL wr_cyc got %0d want 2", o_cyc); end
    n_tests++;
    if (o_done !== 1 || o_done_idx !== 2) begin
      n_fail++; $display("FAIL wr_done got %0d@%0d want 1@2", o_done, o_done_idx);
    end
    n_tests++;
    if (cpu_rdat !== m_rdat) begin
      n_fail++; $display("FAIL wr_rdat got %o want %o", cpu_rdat, m_rdat);
    end
  endtask

  task automatic test_byte_write();
    resp_en = 1'b1; mem = 16'hFFFF;
    run_txn(1'b1, 1'b1, 22'o17777775, 16'h00A5, 1'b1, 8);
    n_tests++; if (o_sel !== 2'b10) begin n_fail++; $display("FAIL bw_sel got %b want 10", o_sel); end
    n_tests++;
    if (o_dat !== 16'hA5A5) begin n_fail++; $display("FAIL bw_dat got %h want a5a5", o_dat); end
    n_tests++; if (o_we !== 1'b1) begin n_fail++; $display("FAIL bw_we got %b want 1", o_we); end
    n_tests++;
    if (o_adr !== 22'o17777774) begin
      n_fail++; $display("FAIL bw_adr got %o want 17777774", o_adr);
    end
    n_tests++;
    if (o_ack !== 1 || o_done !== 1) begin
      n_fail++; $display("FAIL bw_handshake got ack %0d done %0d want 1 1", o_ack, o_done);
    end
    n_tests++;
    if (cpu_rdat !== m_rdat) begin
      n_fail++; $display("FAIL bw_rdat_hold got %h want %h", cpu_rdat, m_rdat);
    end
  endtask

  task automatic test_odd_address();
    resp_en = 1'b1;
    run_txn(1'b0, 1'b0, 22'o17777771, 16'h0, 1'b0, 8);
    n_tests++; if (o_cyc !== 0) begin n_fail++; $display("FAIL odd_cyc got %0d want 0", o_cyc); end
    n_tests++; if (o_odd !== 1) begin n_fail++; $display("FAIL odd_pulse got %0d want 1", o_odd); end
    n_tests++;
    if (o_busy_bad !== 0 || o_done !== 0) begin
      n_fail++; $display("FAIL odd_busy got bad %0d done %0d want 0 0", o_busy_bad, o_done);
    end
  endtask

  task automatic test_timeout();
    resp_en = 1'b0; mem = 16'($urandom);
    run_txn(1'b0, 1'b0, 22'o16000000, 16'h0, 1'b1, TO + 8);
    n_tests++;
    if (o_cyc !== TO) begin n_fail++; $display("FAIL to_cyc got %0d want %0d", o_cyc, TO); end
    n_tests++;
    if (o_to !== 1 || o_to_idx !== TO) begin
      n_fail++; $display("FAIL to_pulse got %0d@%0d want 1@%0d", o_to, o_to_idx, TO);
    end
    n_tests++; if (o_done !== 0) begin n_fail++; $display("FAIL to_done got %0d want 0", o_done); end
    n_tests++;
    if (cpu_rdat !== m_rdat) begin
      n_fail++; $display("FAIL to_rdat got %h want %h", cpu_rdat, m_rdat);
    end
    resp_en = 1'b1;
  endtask

  task automatic test_back_to_back();
    logic [7:0] cyc_v, done_v, ack_v;
    resp_en = 1'b1; mem = 16'h1234;
    cyc_v = '0; done_v = '0; ack_v = '0;
    @(negedge clk);
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_byte = 1'b1; cpu_adr = 22'o17777773;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      cyc_v[i] = wb_cyc_o; done_v[i] = cpu_done; ack_v[i] = wb_ack_i;
      if (i == 3) cpu_req = 1'b0;
    end
    m_rdat = 16'h0012;
    n_tests++;
    if (cyc_v !== 8'h1B) begin n_fail++; $display("FAIL b2b_cyc got %b want 00011011", cyc_v); end
    n_tests++;
    if (done_v !== 8'h24) begin n_fail++; $display("FAIL b2b_done got %b want 00100100", done_v); end
    n_tests++;
    if (ack_v !== 8'h12) begin n_fail++; $display("FAIL b2b_ack got %b want 00010010", ack_v); end
    n_tests++;
    if (cpu_rdat !== m_rdat) begin
      n_fail++; $display("FAIL b2b_rdat got %h want %h", cpu_rdat, m_rdat);
    end
  endtask

  task automatic test_stray_ack();
    int bad;
    bad = 0;
    @(negedge clk);
    stray_ack = 1'b1;
    @(negedge clk);
    stray_ack = 1'b0;
    for (int i = 0; i < 4; i++) begin
      if (wb_cyc_o || cpu_done || cpu_timeout || cpu_busy) bad++;
      @(negedge clk);
    end
    n_tests++;
    if (bad !== 0 || cpu_rdat !== m_rdat) begin
      n_fail++; $display("FAIL stray_ack got bad %0d rdat %h want 0 %h", bad, cpu_rdat, m_rdat);
    end
  endtask

  task automatic test_async_reset();
    int pulses;
    resp_en = 1'b0; pulses = 0;
    @(negedge clk);
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_byte = 1'b0; cpu_adr = 22'o00001000;
    @(negedge clk);
    cpu_req = 1'b0;
    repeat (3) @(negedge clk);
    n_tests++;
    if (wb_cyc_o !== 1'b1) begin n_fail++; $display("FAIL arst_pre_cyc got %b want 1", wb_cyc_o); end
    #2 rst = 1'b1;
    #1;
    n_tests++;
    if ({wb_cyc_o, wb_stb_o, cpu_busy} !== 3'b000) begin
      n_fail++; $display("FAIL arst_drop got cyc%b stb%b busy%b want 000", wb_cyc_o, wb_stb_o,
                         cpu_busy);
    end
    #1 rst = 1'b0;
    m_rdat = 16'h0000;
    for (int i = 0; i < TO + 8; i++) begin
      @(negedge clk);
      if (cpu_done || cpu_timeout || wb_cyc_o) pulses++;
    end
    n_tests++;
    if (pulses !== 0) begin n_fail++; $display("FAIL arst_pulses got %0d want 0", pulses); end
    resp_en = 1'b1; mem = 16'hBEEF;
    run_txn(1'b0, 1'b0, 22'o00002000, 16'h0, 1'b1, 8);
    m_rdat = 16'hBEEF;
    n_tests++;
    if (o_done !== 1 || cpu_rdat !== m_rdat) begin
      n_fail++; $display("FAIL arst_resume got done %0d rdat %h want 1 %h", o_done, cpu_rdat, m_rdat);
    end
  endtask

  task automatic test_random();
    logic          we, byt, ack, odd;
    logic [AW-1:0] adr, e_adr;
    logic [15:0]   wdat, e_dat;
    logic [1:0]    e_sel;
    int            e_cyc;
    for (int t = 0; t < 24; t++) begin
      we = 1'($urandom); byt = 1'($urandom); adr = AW'($urandom); wdat = 16'($urandom);
      ack = ($urandom_range(0, 5) != 0);
      mem = 16'($urandom);
      resp_en = ack;
      odd   = !byt && adr[0];
      e_adr = adr & ~AW'(1);
      e_sel = !byt ? 2'b11 : (adr[0] ? 2'b10 : 2'b01);
      e_dat = byt ? {wdat[7:0], wdat[7:0]} : wdat;
      e_cyc = odd ? 0 : (ack ? 2 : TO);
      if (!odd && ack && !we) m_rdat = !byt ? mem : (adr[0] ? (mem >> 8) : (mem & 16'h00FF));
      run_txn(we, byt, adr, wdat, !odd, (ack || odd) ? 8 : TO + 8);
      n_tests++;
      if (o_cyc !== e_cyc) begin n_fail++; $display("FAIL rnd%0d_cyc got %0d want %0d", t, o_cyc, e_cyc); end
      n_tests++;
      if (o_done !== ((!odd && ack) ? 1 : 0) || o_to !== ((!odd && !ack) ? 1 : 0)
          || o_odd !== (odd ? 1 : 0)) begin
        n_fail++; $display("FAIL rnd%0d_pulses got done %0d to %0d odd %0d", t, o_done, o_to, o_odd);
      end
      n_tests++;
      if (o_ack !== ((!odd && ack) ? 1 : 0)) begin
        n_fail++; $display("FAIL rnd%0d_ack got %0d want %0d", t, o_ack, (!odd && ack) ? 1 : 0);
      end
      n_tests++;
      if (o_busy_bad !== 0 || o_drift !== 0) begin
        n_fail++; $display("FAIL rnd%0d_stable got busy_bad %0d drift %0d want 0 0", t, o_busy_bad,
                           o_drift);
      end
      if (!odd) begin
        n_tests++;
        if ({o_adr, o_sel, o_dat, o_we} !== {e_adr, e_sel, e_dat, we}) begin
          n_fail++; $display("FAIL rnd%0d_lanes got %h/%b/%h/%b want %h/%b/%h/%b", t, o_adr, o_sel,
                             o_dat, o_we, e_adr, e_sel, e_dat, we);
        end
      end
      n_tests++;
      if (cpu_rdat !== m_rdat) begin
        n_fail++; $display("FAIL rnd%0d_rdat got %h want %h", t, cpu_rdat, m_rdat);
      end
    end
    resp_en = 1'b1;
  endtask

  initial begin
    cpu_req = 1'b0; cpu_we = 1'b0; cpu_byte = 1'b0; cpu_adr = '0; cpu_wdat = '0;
    resp_en = 1'b1; stray_ack = 1'b0; mem = '0; m_rdat = '0;
    test_reset();
    test_word_read();
    test_byte_write();
    test_odd_address();
    test_timeout();
    test_back_to_back();
    test_stray_ack();
    test_async_reset();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/cpu_wb_master.md
Name: cpu_wb_master

Overview:
- Wishbone initiator between the PDP2011 CPU core's single-transfer I/O request and the shared Wishbone bus.
- Drives cycles toward responders such as the control-register block, memory and peripherals.
- Handles byte lanes, odd-address rejection, and bus timeout detection.
- Its odd-address and timeout pulses feed the CPU's cpu_address_error and cpu_iobus_timeout inputs.

Parameters:
- AW, 22: physical address width in bits (22-bit PDP-11 physical space).
- TIMEOUT, 64: cycles with stb asserted and no ack before abort. Legal range 2..255.

Ports:
- wb_clk_i  in  1  bus clock; all logic on rising edge.
- wb_rst_i  in  1  reset; asynchronous, active-high.
- cpu_req  in  1  transfer request; sampled only in IDLE.
- cpu_we  in  1  1 = write, 0 = read.
- cpu_byte  in  1  1 = byte access, 0 = word access.
- cpu_adr  in  AW  byte address.
- cpu_wdat  in  16  write data; byte writes use [7:0].
- cpu_rdat  out  16  read data, valid with cpu_done.
- cpu_busy  out  1  high while a transfer is in flight.
- cpu_done  out  1  one-cycle pulse: transfer completed with ack.
- cpu_odd_err  out  1  one-cycle pulse: word access to odd address.
- cpu_timeout  out  1  one-cycle pulse: no ack within TIMEOUT.
- wb_adr_o  out  AW  word-aligned address; bit 0 always 0.
- wb_dat_o  out  16  write data.
- wb_dat_i  in  16  read data.
- wb_cyc_o  out  1  cycle.
- wb_stb_o  out  1  strobe; always equal to wb_cyc_o.
- wb_we_o  out  1  write enable.
- wb_sel_o  out  2  byte lane select: [0] even byte, [1] odd byte.
- wb_ack_i  in  1  responder acknowledge.

Behaviour:
- Reset values: all outputs 0, state IDLE, timeout counter 0.
- Asynchronous reset mid-cycle drops cyc/stb immediately and emits no done, error or timeout pulse.

States: IDLE, BUS.
- IDLE, cpu_req=1, cpu_byte=0, cpu_adr[0]=1:
  - No bus cycle.
  - cpu_odd_err pulses on the next cycle.
  - Remain in IDLE.
- IDLE, cpu_req=1, otherwise:
  - Register wb_adr_o = {cpu_adr[AW-1:1],0}.
  - Register wb_we_o and wb_sel_o, assert cyc/stb, counter := 0, cpu_busy := 1.
  - Go to BUS.
- Lane rules:
  - Word access: sel=11, wb_dat_o=cpu_wdat.
  - Byte access: sel = adr[0] ? 10 : 01, wb_dat_o = {cpu_wdat[7:0], cpu_wdat[7:0]}.
  - Reads use the same sel.
- BUS, wb_ack_i=1:
  - Deassert cyc/stb/we/sel at that edge; pulse cpu_done; cpu_busy := 0; go to IDLE.
  - Read latch: word reads give cpu_rdat=wb_dat_i.
  - Byte reads give cpu_rdat = {8'h00, adr[0] ? wb_dat_i[15:8] : wb_dat_i[7:0]}.
  - cpu_rdat holds its value until the next completed read.
- BUS, no ack, counter == TIMEOUT-1:
  - Deassert cyc/stb; pulse cpu_timeout; cpu_busy := 0; go to IDLE.
  - cpu_rdat unchanged.
- BUS, no ack otherwise: counter increments.
- Ack arriving on the same edge as expiry: ack wins, counter reset, done pulses, no timeout.
- Latency with a zero-wait responder (ack registered one cycle after stb): cyc asserted edge 0, ack seen edge 1, cpu_done high after edge 2.
- Since stb drops on the ack edge, a responder that registers ack as cyc&stb&~ack emits exactly one ack.
- cpu_req while busy is ignored, not queued; the CPU must re-request after done or timeout.
- Back-to-back: a new request is accepted in the IDLE cycle right after done, so cyc is low for at least one cycle between transfers.
- wb_ack_i while in IDLE (stray) is ignored.
- cpu_adr, cpu_wdat and the other request fields are sampled only at acceptance; later changes do not affect the cycle in flight.

Decomposition:
- Shared package cpu_bus_pkg holds:
  - state encoding constants (IDLE=0, BUS=1);
  - sel constants SEL_WORD=2'b11, SEL_EVEN=2'b01, SEL_ODD=2'b10;
  - the default TIMEOUT value.
- One natural sub-module, wb_timeout_cnt: clear/enable inputs and an expire output for the timeout counter.
- Lane steering stays inline.

Test Plan:
- Word read, adr 22'o17777776, zero-wait responder returning 16'o000340:
  - sel=11, cyc high exactly 2 cycles, cpu_done at cycle 2, cpu_rdat=16'o000340.
- Byte write, adr 22'o17777775, wdat 16'h00A5:
  - sel=10, wb_dat_o=16'hA5A5, we=1, wb_adr_o=22'o17777774, one ack, one done.
- Word read, adr 22'o17777771:
  - no cyc ever asserted, cpu_odd_err pulses once, cpu_busy stays 0.
- Read to unmapped address with responder never acking, TIMEOUT=64:
  - cyc drops after exactly 64 cycles, cpu_timeout pulses once, no done, cpu_rdat unchanged.
- Two reads requested back-to-back with byte read adr ...773 (wb_dat_i=16'h1234):
  - cpu_rdat=16'h0012.
  - One idle cycle between cycles, each receives exactly one ack.
- wb_rst_i pulsed asynchronously (between clock edges) while in BUS:
  - cyc/stb drop before the next clock edge, no done/timeout pulse.
  - The next request proceeds normally.
